// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
// Run/pause/lap sequencer for one decade digit. Holds the live count, a
// clock-enable prescaler that paces count steps, and a display latch that
// can be frozen (lap) while counting carries on. All state moves on the
// single system clock; carry pulses for one cycle after a CNT_MAX->0 wrap
// so the next digit's controller can chain off it.
module counter_run_ctrl #(
  parameter int TICK_DIV = 4,
  parameter int CNT_MAX  = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cnt_q,
  output logic [3:0] disp,
  output logic       carry,
  output logic       running,
  output logic       held
);

  // With TICK_DIV=1 the prescaler is a single bit that never leaves zero,
  // so every counting edge is a step edge.
  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0]    CNT_TOP  = 4'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nxt;
  logic [3:0]    cnt_nxt;
  logic [3:0]    disp_nxt;
  logic          carry_nxt;
  logic          count_en;
  logic          step;

  // Next-state decode; clear outranks start_stop, which outranks lap.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop) state_nxt = RUN;
        RUN:     if (start_stop) state_nxt = PAUSE;
                 else if (lap)   state_nxt = LAP;
        LAP:     if (start_stop) state_nxt = PAUSE;
                 else if (lap)   state_nxt = RUN;
        PAUSE:   if (start_stop) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath next values. Counting is judged on the state before the edge,
  // so the edge leaving RUN still counts and the edge leaving PAUSE does not.
  // The display only holds while we stay in LAP; on entry and exit it takes
  // the new count so it shows the value present after that edge.
  always_comb begin
    count_en  = (state == RUN) || (state == LAP);
    step      = count_en && (pre == PRE_LAST);
    pre_nxt   = pre;
    cnt_nxt   = cnt_q;
    carry_nxt = 1'b0;
    if (count_en) begin
      pre_nxt = step ? '0 : pre + 1'b1;
    end
    if (step) begin
      if (cnt_q == CNT_TOP) begin
        cnt_nxt   = 4'd0;
        carry_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + 4'd1;
      end
    end
    if (state == IDLE && start_stop) begin
      pre_nxt = '0;
    end
    if (clear) begin
      pre_nxt   = '0;
      cnt_nxt   = 4'd0;
      carry_nxt = 1'b0;
    end
    disp_nxt = ((state == LAP) && (state_nxt == LAP)) ? disp : cnt_nxt;
  end

  // State and datapath registers; reset clears everything with no clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pre     <= '0;
      cnt_q   <= 4'd0;
      disp    <= 4'd0;
      carry   <= 1'b0;
      running <= 1'b0;
      held    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pre     <= pre_nxt;
      cnt_q   <= cnt_nxt;
      disp    <= disp_nxt;
      carry   <= carry_nxt;
      running <= (state_nxt == RUN) || (state_nxt == LAP);
      held    <= (state_nxt == LAP);
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl
// Directed bench for counter_run_ctrl. Two instances: one at TICK_DIV=4,
// one at TICK_DIV=1. Stimulus pushes hand-computed expectations onto a
// scoreboard queue; a monitor on the falling edge pops and compares.
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ss0, clr0, lap0;
  logic       ss1, clr1, lap1;
  logic [3:0] cnt0, disp0, cnt1, disp1;
  logic       carry0, running0, held0;
  logic       carry1, running1, held1;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    int         sel;
    string      name;
    logic [3:0] cnt;
    logic [3:0] disp;
    logic       carry;
    logic       running;
    logic       held;
  } exp_t;

  exp_t sb[$];
  exp_t monE;

  counter_run_ctrl #(.TICK_DIV(4), .CNT_MAX(9)) dut (
    .clk(clk), .reset(reset), .start_stop(ss0), .clear(clr0), .lap(lap0),
    .cnt_q(cnt0), .disp(disp0), .carry(carry0), .running(running0), .held(held0)
  );

  counter_run_ctrl #(.TICK_DIV(1), .CNT_MAX(9)) dut1 (
    .clk(clk), .reset(reset), .start_stop(ss1), .clear(clr1), .lap(lap1),
    .cnt_q(cnt1), .disp(disp1), .carry(carry1), .running(running1), .held(held1)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop if the run ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s.%s actual=%0d required=%0d", nm, fld, act, exp);
  endtask

  // Monitor: compare one queued expectation against the chosen instance.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      monE = sb.pop_front();
      if (monE.sel == 0) begin
        cmp(monE.name, "cnt_q",   int'(cnt0),     int'(monE.cnt));
        cmp(monE.name, "disp",    int'(disp0),    int'(monE.disp));
        cmp(monE.name, "carry",   int'(carry0),   int'(monE.carry));
        cmp(monE.name, "running", int'(running0), int'(monE.running));
        cmp(monE.name, "held",    int'(held0),    int'(monE.held));
      end else begin
        cmp(monE.name, "cnt_q",   int'(cnt1),     int'(monE.cnt));
        cmp(monE.name, "disp",    int'(disp1),    int'(monE.disp));
        cmp(monE.name, "carry",   int'(carry1),   int'(monE.carry));
        cmp(monE.name, "running", int'(running1), int'(monE.running));
        cmp(monE.name, "held",    int'(held1),    int'(monE.held));
      end
    end
  end

  // Drive one cycle of pulses to the selected instance, then drop them.
  task automatic applyStimulus(input int sel, input logic ss, input logic clr, input logic lp);
    if (sel == 0) begin
      ss0 = ss; clr0 = clr; lap0 = lp;
    end else begin
      ss1 = ss; clr1 = clr; lap1 = lp;
    end
    @(posedge clk);
    #1;
    ss0 = 1'b0; clr0 = 1'b0; lap0 = 1'b0;
    ss1 = 1'b0; clr1 = 1'b0; lap1 = 1'b0;
  endtask

  // Queue an expectation and wait (bounded) for the monitor to consume it.
  task automatic checkOutput(input int sel, input string nm, input logic [3:0] c,
                             input logic [3:0] d, input logic cy, input logic r,
                             input logic h);
    exp_t e;
    int   tries;
    e.sel = sel; e.name = nm; e.cnt = c; e.disp = d;
    e.carry = cy; e.running = r; e.held = h;
    sb.push_back(e);
    tries = 0;
    while (sb.size() != 0 && tries < 4) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (sb.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL %s.scoreboard actual=pending required=consumed", nm);
      sb.delete();
    end
  endtask

  initial begin
    logic [3:0] c;
    reset = 1'b0;
    ss0 = 1'b0; clr0 = 1'b0; lap0 = 1'b0;
    ss1 = 1'b0; clr1 = 1'b0; lap1 = 1'b0;
    #2;
    checkOutput(0, "resetInit", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(1, "resetInit1", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Start, then 40 counting edges: one step per 4 edges, wrap at edge 40.
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "start", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      c = 4'((k / 4) % 10);
      checkOutput(0, "run40", c, c, (k == 40), 1'b1, 1'b0);
    end

    // Reach cnt=3 with prescaler=2 (pause edge is the 14th counting edge).
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      c = 4'(k / 4);
      checkOutput(0, "run13", c, c, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "pause", 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      checkOutput(0, "paused", 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "resume", 4'd3, 4'd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput(0, "resume1", 4'd3, 4'd3, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput(0, "resume2", 4'd4, 4'd4, 1'b0, 1'b1, 1'b0);

    // Lap at cnt=5: display holds while the count moves on.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      checkOutput(0, "preLap", 4'd4, 4'd4, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, "lapIn", 4'd5, 4'd5, 1'b0, 1'b1, 1'b1);
    for (int j = 1; j <= 10; j++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      c = 4'(5 + j / 4);
      checkOutput(0, "lapHold", c, 4'd5, 1'b0, 1'b1, 1'b1);
    end
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, "lapOut", 4'd7, 4'd7, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput(0, "lapOut1", 4'd8, 4'd8, 1'b0, 1'b1, 1'b0);

    // Clear together with start_stop: clear wins, back to IDLE.
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    checkOutput(0, "clrSs", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      checkOutput(0, "clrIdle", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end

    // Clear on the wrap edge: no carry escapes.
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "start2", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 39; k++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      c = 4'(k / 4);
      checkOutput(0, "toNine", c, c, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    checkOutput(0, "clrStep", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput(0, "clrStep1", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Lap ignored in IDLE; start_stop beats lap in RUN; lap ignored in PAUSE.
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, "idleLap", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "start3", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    checkOutput(0, "ssLap", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    checkOutput(0, "pauseLap", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput(0, "resume3", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Prescaler sits at 1: first step after 3 edges, then every 4.
    for (int n = 1; n <= 29; n++) begin
      applyStimulus(0, 1'b0, 1'b0, 1'b0);
      c = 4'((n + 1) / 4);
      checkOutput(0, "toSeven", c, c, 1'b0, 1'b1, 1'b0);
    end
    // Async reset between edges at cnt=7.
    #1;
    reset = 1'b0;
    checkOutput(0, "asyncRst", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    checkOutput(0, "postRst", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // TICK_DIV=1 instance: steps every edge, carry after each 9->0 wrap.
    applyStimulus(1, 1'b1, 1'b0, 1'b0);
    checkOutput(1, "start1", 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 35; k++) begin
      applyStimulus(1, 1'b0, 1'b0, 1'b0);
      c = 4'(k % 10);
      checkOutput(1, "fast", c, c, (k % 10 == 0), 1'b1, 1'b0);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
